// File: rtl/uart_rx_cmd_ctrl_if.sv
// uart_rx_cmd_ctrl_if: received-byte input and request output bundle for uart_rx_cmd_ctrl
//  i_rx_valid/i_rx_data/i_parity_error/i_stop_error : byte from the UART receiver
//  i_ready                                           : downstream accepts current request
//  o_reg_wr_en/o_reg_rd_en/o_reg_addr/o_reg_wr_data  : register-file request
//  o_alu_en/o_alu_op_a/o_alu_op_b/o_alu_fun          : ALU request
//  o_frame_err/o_overrun/o_busy                      : status
interface uart_rx_cmd_ctrl_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int FUN_WIDTH  = 4
);
    logic                  i_rx_valid;
    logic [WIDTH-1:0]      i_rx_data;
    logic                  i_parity_error;
    logic                  i_stop_error;
    logic                  i_ready;
    logic                  o_reg_wr_en;
    logic                  o_reg_rd_en;
    logic [ADDR_WIDTH-1:0] o_reg_addr;
    logic [WIDTH-1:0]      o_reg_wr_data;
    logic                  o_alu_en;
    logic [WIDTH-1:0]      o_alu_op_a;
    logic [WIDTH-1:0]      o_alu_op_b;
    logic [FUN_WIDTH-1:0]  o_alu_fun;
    logic                  o_frame_err;
    logic                  o_overrun;
    logic                  o_busy;
    modport slave (
        input  i_rx_valid, i_rx_data, i_parity_error, i_stop_error, i_ready,
        output o_reg_wr_en, o_reg_rd_en, o_reg_addr, o_reg_wr_data,
               o_alu_en, o_alu_op_a, o_alu_op_b, o_alu_fun,
               o_frame_err, o_overrun, o_busy
    );
    modport master (
        output i_rx_valid, i_rx_data, i_parity_error, i_stop_error, i_ready,
        input  o_reg_wr_en, o_reg_rd_en, o_reg_addr, o_reg_wr_data,
               o_alu_en, o_alu_op_a, o_alu_op_b, o_alu_fun,
               o_frame_err, o_overrun, o_busy
    );
endinterface

// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: parses UART command frames into register-file and ALU requests
//  i_clk : system clock
//  i_rst : asynchronous reset, active-high
//  bus   : byte input, valid/ready request output and status (uart_rx_cmd_ctrl_if.slave)
module uart_rx_cmd_ctrl #(
    parameter int              WIDTH       = 8,
    parameter int              ADDR_WIDTH  = 4,
    parameter int              FUN_WIDTH   = 4,
    parameter int              TIMEOUT     = 1024,
    parameter logic [WIDTH-1:0] CMD_WR      = 'hAA,
    parameter logic [WIDTH-1:0] CMD_RD      = 'hBB,
    parameter logic [WIDTH-1:0] CMD_ALU_OP  = 'hCC,
    parameter logic [WIDTH-1:0] CMD_ALU_NOP = 'hDD
) (
    input logic               i_clk,
    input logic               i_rst,
    uart_rx_cmd_ctrl_if.slave bus
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [3:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, ALU_A, ALU_B, ALU_FUN, NOP_FUN, ISSUE} state_e;
    typedef enum logic [1:0] {REQ_WR, REQ_RD, REQ_ALU} req_e;
    state_e                state_q, state_d;
    req_e                  req_q, req_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WIDTH-1:0]      tmp_a_q, tmp_a_d, tmp_b_q, tmp_b_d;
    logic [WIDTH-1:0]      op_a_q, op_a_d, op_b_q, op_b_d, wr_data_q, wr_data_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [FUN_WIDTH-1:0]  fun_q, fun_d;
    logic                  frame_err_q, frame_err_d, overrun_q, overrun_d;
    logic [WIDTH-1:0]      d;
    logic                  rx_good, rx_bad;
    assign d       = bus.i_rx_data;
    assign rx_good = bus.i_rx_valid && !bus.i_parity_error && !bus.i_stop_error;
    assign rx_bad  = bus.i_rx_valid && (bus.i_parity_error || bus.i_stop_error);
    // Partial fields live in tmp_a/tmp_b; visible outputs change only when a frame completes.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = '0;
        tmp_a_d     = tmp_a_q;
        tmp_b_d     = tmp_b_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        wr_data_d   = wr_data_q;
        addr_d      = addr_q;
        fun_d       = fun_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = !rx_good ? IDLE :
                          d == CMD_WR ? WR_ADDR :
                          d == CMD_RD ? RD_ADDR :
                          d == CMD_ALU_OP ? ALU_A :
                          d == CMD_ALU_NOP ? NOP_FUN : IDLE;
                frame_err_d = rx_bad || (rx_good && state_d == IDLE);
            end
            ISSUE: begin
                overrun_d = bus.i_rx_valid;
                state_d   = bus.i_ready ? IDLE : ISSUE;
            end
            default: begin
                if (rx_bad) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else if (rx_good) begin
                    case (state_q)
                        WR_ADDR: begin
                            tmp_a_d = d;
                            state_d = WR_DATA;
                        end
                        WR_DATA: begin
                            addr_d    = tmp_a_q[ADDR_WIDTH-1:0];
                            wr_data_d = d;
                            req_d     = REQ_WR;
                            state_d   = ISSUE;
                        end
                        RD_ADDR: begin
                            addr_d  = d[ADDR_WIDTH-1:0];
                            req_d   = REQ_RD;
                            state_d = ISSUE;
                        end
                        ALU_A: begin
                            tmp_a_d = d;
                            state_d = ALU_B;
                        end
                        ALU_B: begin
                            tmp_b_d = d;
                            state_d = ALU_FUN;
                        end
                        ALU_FUN: begin
                            op_a_d  = tmp_a_q;
                            op_b_d  = tmp_b_q;
                            fun_d   = d[FUN_WIDTH-1:0];
                            req_d   = REQ_ALU;
                            state_d = ISSUE;
                        end
                        default: begin
                            fun_d   = d[FUN_WIDTH-1:0];
                            req_d   = REQ_ALU;
                            state_d = ISSUE;
                        end
                    endcase
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d     = IDLE;
                    frame_err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_q       <= REQ_WR;
            cnt_q       <= '0;
            tmp_a_q     <= '0;
            tmp_b_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            wr_data_q   <= '0;
            addr_q      <= '0;
            fun_q       <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            tmp_a_q     <= tmp_a_d;
            tmp_b_q     <= tmp_b_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            wr_data_q   <= wr_data_d;
            addr_q      <= addr_d;
            fun_q       <= fun_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end
    assign bus.o_reg_wr_en   = state_q == ISSUE && req_q == REQ_WR;
    assign bus.o_reg_rd_en   = state_q == ISSUE && req_q == REQ_RD;
    assign bus.o_alu_en      = state_q == ISSUE && req_q == REQ_ALU;
    assign bus.o_reg_addr    = addr_q;
    assign bus.o_reg_wr_data = wr_data_q;
    assign bus.o_alu_op_a    = op_a_q;
    assign bus.o_alu_op_b    = op_b_q;
    assign bus.o_alu_fun     = fun_q;
    assign bus.o_frame_err   = frame_err_q;
    assign bus.o_overrun     = overrun_q;
    assign bus.o_busy        = state_q != IDLE;
endmodule
